// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU controller:
// operations, FSM states and 1-bit slice control words.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_SLT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;

  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_SUB = 3'b001;
  localparam logic [2:0] CTRL_XOR = 3'b100;

  function automatic logic [2:0] slice_ctrl(
    input op_e o
  );
    logic [2:0] c;
    c = CTRL_ADD;
    unique case (1'b1)
      (o == OP_XOR): c = CTRL_XOR;
      (o == OP_SUB),
      (o == OP_SLT): c = CTRL_SUB;
      default:       c = CTRL_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_slice_1bit.sv
// One-bit ALU slice: add, subtract (B inverted) or xor.
// Carry-out is held low in xor mode.
module alu_slice_1bit
  import alu_pkg::*;
(
  output logic       out,
  output logic       cout,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] cntrl
);

  logic bx;

  assign bx = b ^ cntrl[0];

  always_comb begin
    out  = 1'b0;
    cout = 1'b0;
    case (cntrl)
      CTRL_XOR: out = a ^ b;
      CTRL_ADD,
      CTRL_SUB: begin
        out  = a ^ bx ^ cin;
        cout = (a & bx) | (a & cin) |
               (bx & cin);
      end
      default: begin
        out  = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: one bit per cycle, LSB first,
// through a single 1-bit slice; result and flags land at RUN->FIN.
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sres_q, sres_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             s_out;
  logic             s_cout;
  logic [2:0]       s_ctrl;
  logic [WIDTH-1:0] sres_sh;
  logic [WIDTH-1:0] res_w;
  logic             is_xor;
  logic             ovf_w;

  assign s_ctrl  = slice_ctrl(op_q);
  assign is_xor  = (op_q == OP_XOR);
  assign sres_sh = {s_out, sres_q[WIDTH-1:1]};
  // on the last bit, carry_q is the carry into the MSB
  assign ovf_w   = carry_q ^ s_cout;

  alu_slice_1bit u_slice (
    .out   (s_out),
    .cout  (s_cout),
    .a     (a_q[0]),
    .b     (b_q[0]),
    .cin   (carry_q),
    .cntrl (s_ctrl)
  );

  always_comb begin
    res_w = sres_sh;
    if (op_q == OP_SLT) begin
      res_w    = '0;
      res_w[0] = s_out ^ ovf_w;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sres_d   = sres_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          op_d    = op_e'(op);
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          carry_d = op[0];
          sres_d  = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          a_d     = {1'b0, a_q[WIDTH-1:1]};
          b_d     = {1'b0, b_q[WIDTH-1:1]};
          sres_d  = sres_sh;
          carry_d = s_cout;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d  = FIN;
            result_d = res_w;
            cout_d   = is_xor ? 1'b0 : s_cout;
            ovf_d    = is_xor ? 1'b0 : ovf_w;
            zero_d   = (res_w == '0);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sres_q   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sres_q   <= sres_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FIN);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed self-checking bench for serial_alu_ctrl at WIDTH=32.
// Outputs are sampled on the falling clock edge.
module tb_serial_alu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;

  int chk_cnt;
  int pass_cnt;

  serial_alu_ctrl #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // start in cycle 0; returns cycle index of done (-1 on timeout)
  task automatic run_op(
    input  logic [1:0]  o,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output int          lat
  );
    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    lat   = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
    else pass_cnt++;
    chk_cnt++;
    if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done);
    else pass_cnt++;
    chk_cnt++;
    if (result !== 32'h0)
      $display("FAIL rst_result got %h want 0", result);
    else pass_cnt++;
    chk_cnt++;
    if (zero !== 1'b1) $display("FAIL rst_zero got %b want 1", zero);
    else pass_cnt++;
    chk_cnt++;
    if ({cout, ovf} !== 2'b00)
      $display("FAIL rst_flags got %b want 00", {cout, ovf});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    int lat;
    run_op(2'b00, 32'hFFFF_FFFF, 32'h1, lat);
    chk_cnt++;
    if (lat !== 33) $display("FAIL add_latency got %0d want 33", lat);
    else pass_cnt++;
    chk_cnt++;
    if (result !== 32'h0)
      $display("FAIL add_result got %h want 0", result);
    else pass_cnt++;
    chk_cnt++;
    if ({cout, ovf, zero} !== 3'b101)
      $display("FAIL add_flags got %b want 101", {cout, ovf, zero});
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL add_busy_fin got %b want 1", busy);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({done, busy} !== 2'b00)
      $display("FAIL add_done_pulse got %b want 00", {done, busy});
    else pass_cnt++;
  endtask

  task automatic test_sub;
    int lat;
    run_op(2'b01, 32'h8000_0000, 32'h1, lat);
    chk_cnt++;
    if (result !== 32'h7FFF_FFFF)
      $display("FAIL sub_result got %h want 7fffffff", result);
    else pass_cnt++;
    chk_cnt++;
    if ({cout, ovf, zero} !== 3'b110)
      $display("FAIL sub_flags got %b want 110", {cout, ovf, zero});
    else pass_cnt++;
    chk_cnt++;
    if (lat !== 33) $display("FAIL sub_latency got %0d want 33", lat);
    else pass_cnt++;
  endtask

  task automatic test_xor;
    int lat;
    run_op(2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    chk_cnt++;
    if (result !== 32'h0FF0_0FF0)
      $display("FAIL xor_result got %h want 0ff00ff0", result);
    else pass_cnt++;
    chk_cnt++;
    if ({cout, ovf, zero} !== 3'b000)
      $display("FAIL xor_flags got %b want 000", {cout, ovf, zero});
    else pass_cnt++;
  endtask

  task automatic test_slt;
    int lat;
    run_op(2'b11, 32'hFFFF_FFFF, 32'h1, lat);
    chk_cnt++;
    if (result !== 32'h1)
      $display("FAIL slt_neg_result got %h want 1", result);
    else pass_cnt++;
    chk_cnt++;
    if ({cout, ovf, zero} !== 3'b100)
      $display("FAIL slt_neg_flags got %b want 100", {cout, ovf, zero});
    else pass_cnt++;
    run_op(2'b11, 32'h7FFF_FFFF, 32'h8000_0000, lat);
    chk_cnt++;
    if (result !== 32'h0)
      $display("FAIL slt_ovf_result got %h want 0", result);
    else pass_cnt++;
    chk_cnt++;
    if ({cout, ovf, zero} !== 3'b011)
      $display("FAIL slt_ovf_flags got %b want 011", {cout, ovf, zero});
    else pass_cnt++;
  endtask

  task automatic test_start_ignored;
    int ndone;
    int lat;
    ndone = 0;
    lat   = -1;
    @(negedge clk);
    op    = 2'b00;
    a     = 32'd5;
    b     = 32'd6;
    start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = (k == 5);
      if (k == 5) begin
        op = 2'b10;
        a  = 32'hDEAD_BEEF;
        b  = 32'h1234_5678;
      end
      if (done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
    end
    chk_cnt++;
    if (result !== 32'd11)
      $display("FAIL ign_result got %h want 0000000b", result);
    else pass_cnt++;
    chk_cnt++;
    if (ndone !== 1) $display("FAIL ign_done_count got %0d want 1", ndone);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== 33) $display("FAIL ign_latency got %0d want 33", lat);
    else pass_cnt++;
  endtask

  task automatic test_abort;
    int   lat;
    int   ndone;
    logic busy11;
    run_op(2'b00, 32'h10, 32'h20, lat);
    chk_cnt++;
    if (result !== 32'h30)
      $display("FAIL abt_pre_result got %h want 30", result);
    else pass_cnt++;
    ndone  = 0;
    busy11 = 1'b1;
    @(negedge clk);
    op    = 2'b01;
    a     = 32'd100;
    b     = 32'd1;
    start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (k == 10);
      if (k == 11) busy11 = busy;
      if (done) ndone++;
    end
    chk_cnt++;
    if (busy11 !== 1'b0)
      $display("FAIL abt_idle got busy %b want 0", busy11);
    else pass_cnt++;
    chk_cnt++;
    if (ndone !== 0) $display("FAIL abt_no_done got %0d want 0", ndone);
    else pass_cnt++;
    chk_cnt++;
    if ({result, zero} !== {32'h30, 1'b0})
      $display("FAIL abt_hold got %h/%b want 30/0", result, zero);
    else pass_cnt++;
    run_op(2'b00, 32'd1, 32'd2, lat);
    chk_cnt++;
    if (result !== 32'd3 || lat !== 33)
      $display("FAIL abt_after got %h lat %0d want 3 lat 33",
               result, lat);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    int lat;
    @(negedge clk);
    op    = 2'b00;
    a     = 32'd9;
    b     = 32'd9;
    start = 1'b1;
    repeat (8) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy);
    else pass_cnt++;
    chk_cnt++;
    if (result !== 32'h0)
      $display("FAIL rmid_result got %h want 0", result);
    else pass_cnt++;
    chk_cnt++;
    if (zero !== 1'b1) $display("FAIL rmid_zero got %b want 1", zero);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 32'd3, 32'd4, lat);
    chk_cnt++;
    if (result !== 32'd7)
      $display("FAIL rmid_add got %h want 7", result);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== 33) $display("FAIL rmid_latency got %0d want 33", lat);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(2'b10, 32'hAAAA_5555, 32'hFFFF_0000, lat);
    chk_cnt++;
    if (result !== 32'h5555_5555)
      $display("FAIL b2b_first got %h want 55555555", result);
    else pass_cnt++;
    // next start lands in the first IDLE cycle after FIN
    run_op(2'b01, 32'd5, 32'd7, lat);
    chk_cnt++;
    if (lat !== 33) $display("FAIL b2b_latency got %0d want 33", lat);
    else pass_cnt++;
    chk_cnt++;
    if (result !== 32'hFFFF_FFFE)
      $display("FAIL b2b_second got %h want fffffffe", result);
    else pass_cnt++;
    chk_cnt++;
    if ({cout, ovf, zero} !== 3'b000)
      $display("FAIL b2b_flags got %b want 000", {cout, ovf, zero});
    else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    op       = 2'b00;
    a        = '0;
    b        = '0;
    test_reset();
    test_add();
    test_sub();
    test_xor();
    test_slt();
    test_start_ignored();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
